// File: rtl/fringe_pkg.sv
// Shared constants for the fringe/edge noise decision pipeline: defaults,
// correction modes and the direction-to-window-index pair table.
package fringe_pkg;

  localparam int PIXEL_W_DEF  = 8;
  localparam int TH_A_RST_DEF = 25;
  localparam int TH_B_RST_DEF = 80;
  localparam int CNT_W_DEF    = 24;

  localparam logic [1:0] MODE_ZERO = 2'd0;
  localparam logic [1:0] MODE_PASS = 2'd1;
  localparam logic [1:0] MODE_DIR  = 2'd2;

  typedef enum logic [1:0] {E1 = 2'd0, E2 = 2'd1, E3 = 2'd2, E4 = 2'd3} dir_e;

  localparam int NUM_DIR    = 4;
  localparam int CENTRE_IDX = 4;

  // Window slice index of each pair end: E1=(a,h) E2=(c,f) E3=(b,g) E4=(d,e)
  function automatic int pair_p(input int k);
    case (k)
      0:       return 0;
      1:       return 2;
      2:       return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int pair_q(input int k);
    case (k)
      0:       return 8;
      1:       return 6;
      2:       return 7;
      default: return 5;
    endcase
  endfunction

endpackage

// File: rtl/fringe_decision_pipe_abs_diff_w.sv
// Combinational unsigned absolute difference |x-y| in W bits.
module abs_diff_w #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_x,
  input  logic [W-1:0] i_y,
  output logic [W-1:0] o_d
);

  assign o_d = (i_x >= i_y) ? (i_x - i_y) : (i_y - i_x);

endmodule

// File: rtl/fringe_decision_pipe.sv
// Two-stage valid/ready noise decision on a 3x3 window: classifies the centre,
// corrects it per mode and counts noisy pixels per frame.
module fringe_decision_pipe
  import fringe_pkg::*;
#(
  parameter int PIXEL_W  = PIXEL_W_DEF,
  parameter int TH_A_RST = TH_A_RST_DEF,
  parameter int TH_B_RST = TH_B_RST_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic                 iClk,
  input  logic                 iRst,
  input  logic                 iEn,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [9*PIXEL_W-1:0] ivWin,
  input  logic                 iSof,
  input  logic                 iEof,
  input  logic                 iCfgWe,
  input  logic [PIXEL_W-1:0]   ivThA,
  input  logic [PIXEL_W-1:0]   ivThB,
  input  logic [1:0]           iv2Mode,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [PIXEL_W-1:0]   ovPixel,
  output logic                 oNoisy,
  output logic                 oSof,
  output logic                 oEof,
  output logic [CNT_W-1:0]     ovNoisyCnt,
  output logic                 oCntValid
);

  function automatic logic [PIXEL_W-1:0] round_mean(input logic [PIXEL_W-1:0] p,
                                                    input logic [PIXEL_W-1:0] q);
    logic [PIXEL_W:0] s;
    s = {1'b0, p} + {1'b0, q} + (PIXEL_W+1)'(1);
    return s[PIXEL_W:1];
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic inc);
    if (inc && (c != {CNT_W{1'b1}})) return c + CNT_W'(1);
    return c;
  endfunction

  logic [PIXEL_W-1:0]   r_tha, r_thb;
  logic [1:0]           r_mode;
  logic                 r_vld_p1, r_sof_p1, r_eof_p1, r_en_p1;
  logic [9*PIXEL_W-1:0] r_win_p1;
  logic [PIXEL_W-1:0]   r_tha_p1, r_thb_p1;
  logic [1:0]           r_mode_p1;
  logic                 r_vld_p2, r_noisy_p2, r_sof_p2, r_eof_p2, r_en_p2;
  logic [PIXEL_W-1:0]   r_pix_p2;
  logic [CNT_W-1:0]     r_cnt, r_cnt_out, w_cnt_next;
  logic                 r_cnt_vld;
  logic                 w_adv_p1, w_adv_p2, w_hs_out;
  logic [PIXEL_W-1:0]   w_fij, w_pix;
  logic [PIXEL_W-1:0]   w_p [NUM_DIR];
  logic [PIXEL_W-1:0]   w_q [NUM_DIR];
  logic [PIXEL_W-1:0]   w_dpf [NUM_DIR];
  logic [PIXEL_W-1:0]   w_dqf [NUM_DIR];
  logic [PIXEL_W-1:0]   w_dpq [NUM_DIR];
  logic [NUM_DIR-1:0]   w_cons;
  logic                 w_noisy;
  dir_e                 w_best;
  logic [PIXEL_W-1:0]   w_best_d;

  assign w_hs_out = r_vld_p2 & iReady;
  assign w_adv_p2 = ~r_vld_p2 | iReady;
  assign w_adv_p1 = ~r_vld_p1 | w_adv_p2;
  assign oReady   = w_adv_p1;

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_tha  <= PIXEL_W'(TH_A_RST);
      r_thb  <= PIXEL_W'(TH_B_RST);
      r_mode <= MODE_ZERO;
    end else if (iCfgWe) begin
      r_tha  <= ivThA;
      r_thb  <= ivThB;
      r_mode <= iv2Mode;
    end
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_vld_p1 <= 1'b0;
      r_vld_p2 <= 1'b0;
    end else begin
      if (w_adv_p1) r_vld_p1 <= iValid;
      if (w_adv_p2) r_vld_p2 <= r_vld_p1;
    end
  end

  // ---- S1: window, flags and the configuration the beat was accepted with
  always_ff @(posedge iClk) begin
    if (w_adv_p1 && iValid) begin
      r_win_p1  <= ivWin;
      r_sof_p1  <= iSof;
      r_eof_p1  <= iEof;
      r_en_p1   <= iEn;
      r_tha_p1  <= r_tha;
      r_thb_p1  <= r_thb;
      r_mode_p1 <= r_mode;
    end
  end

  assign w_fij = r_win_p1[CENTRE_IDX*PIXEL_W +: PIXEL_W];

  for (genvar k = 0; k < NUM_DIR; k++) begin : g_dir
    localparam int P = pair_p(k);
    localparam int Q = pair_q(k);
    assign w_p[k] = r_win_p1[P*PIXEL_W +: PIXEL_W];
    assign w_q[k] = r_win_p1[Q*PIXEL_W +: PIXEL_W];
    abs_diff_w #(.W(PIXEL_W)) u_pf (.i_x(w_p[k]), .i_y(w_fij),  .o_d(w_dpf[k]));
    abs_diff_w #(.W(PIXEL_W)) u_qf (.i_x(w_q[k]), .i_y(w_fij),  .o_d(w_dqf[k]));
    abs_diff_w #(.W(PIXEL_W)) u_pq (.i_x(w_p[k]), .i_y(w_q[k]), .o_d(w_dpq[k]));
    assign w_cons[k] = (w_dpf[k] < r_tha_p1) && (w_dqf[k] < r_tha_p1) && (w_dpq[k] < r_thb_p1);
  end

  // Strict less-than keeps the lowest direction on equal pair spreads
  always_comb begin
    w_best   = E1;
    w_best_d = w_dpq[0];
    for (int k = 1; k < NUM_DIR; k++) begin
      if (w_dpq[k] < w_best_d) begin
        w_best   = dir_e'(k[1:0]);
        w_best_d = w_dpq[k];
      end
    end
    w_noisy = r_en_p1 & ~|w_cons;
    w_pix   = w_fij;
    if (w_noisy) begin
      if (r_mode_p1 == MODE_ZERO)      w_pix = '0;
      else if (r_mode_p1 == MODE_PASS) w_pix = w_fij;
      else                             w_pix = round_mean(w_p[w_best], w_q[w_best]);
    end
  end

  // ---- S2: decision and corrected pixel
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_pix_p2   <= '0;
      r_noisy_p2 <= 1'b0;
      r_sof_p2   <= 1'b0;
      r_eof_p2   <= 1'b0;
      r_en_p2    <= 1'b0;
    end else if (w_adv_p2 && r_vld_p1) begin
      r_pix_p2   <= w_pix;
      r_noisy_p2 <= w_noisy;
      r_sof_p2   <= r_sof_p1;
      r_eof_p2   <= r_eof_p1;
      r_en_p2    <= r_en_p1;
    end
  end

  always_comb begin
    w_cnt_next = r_cnt;
    if (r_sof_p2) w_cnt_next = CNT_W'(r_noisy_p2);
    else          w_cnt_next = sat_inc(r_cnt, r_noisy_p2);
  end

  // Bypassed beats leave the frame counter untouched
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_cnt     <= '0;
      r_cnt_out <= '0;
      r_cnt_vld <= 1'b0;
    end else begin
      r_cnt_vld <= 1'b0;
      if (w_hs_out && r_en_p2) begin
        r_cnt <= w_cnt_next;
        if (r_eof_p2) begin
          r_cnt_out <= w_cnt_next;
          r_cnt_vld <= 1'b1;
        end
      end
    end
  end

  assign oValid     = r_vld_p2;
  assign ovPixel    = r_pix_p2;
  assign oNoisy     = r_noisy_p2;
  assign oSof       = r_sof_p2;
  assign oEof       = r_eof_p2;
  assign ovNoisyCnt = r_cnt_out;
  assign oCntValid  = r_cnt_vld;

endmodule
